// File: rtl/ascon_pack.sv
// Shared Ascon-128 datapath types: the 5 x 64-bit permutation state and the
// mode codes used by the xor stages that wrap the permutation rounds.
package ascon_pack;

    typedef logic [0:4][63:0] type_state;

    localparam logic [1:0] XOR_PASS = 2'b00;
    localparam logic [1:0] XOR_DATA = 2'b01;
    localparam logic [1:0] XOR_KEY  = 2'b10;
    localparam logic [1:0] XOR_BOTH = 2'b11;

endpackage

// File: rtl/xor_up.sv
// Purpose: absorb a data block into S0 and/or the key into S1||S2 ahead of the rounds.
// Latency: 1 cycle from en_i to xor_o; reset clears xor_o asynchronously.
// Backpressure: none; en_i=0 simply holds the registered state.
module xor_up
    import ascon_pack::*;
(
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          en_i,
    input  logic [1:0]    etat_i,
    input  logic [127:0]  xor_key_i,
    input  logic [63:0]   xor_data_i,
    input  type_state     xor_i,
    output type_state     xor_o
);

    type_state xor_d;
    type_state xor_q;

    // S3/S4 are never touched; the key halves land high-first in S1 then S2.
    always_comb begin
        xor_d = xor_i;
        case (etat_i)
            XOR_DATA: begin
                xor_d[0] = xor_i[0] ^ xor_data_i;
            end
            XOR_KEY: begin
                xor_d[1] = xor_i[1] ^ xor_key_i[127:64];
                xor_d[2] = xor_i[2] ^ xor_key_i[63:0];
            end
            XOR_BOTH: begin
                xor_d[0] = xor_i[0] ^ xor_data_i;
                xor_d[1] = xor_i[1] ^ xor_key_i[127:64];
                xor_d[2] = xor_i[2] ^ xor_key_i[63:0];
            end
            default: begin
                xor_d = xor_i;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            xor_q <= '0;
        end else if (en_i) begin
            xor_q <= xor_d;
        end
    end

    assign xor_o = xor_q;

endmodule

// File: tb/tb_xor_up.sv
// Self-checking bench for xor_up: directed vectors followed by randomized traffic
// compared against a mask-based reference of the absorb operation.
module tb_xor_up;
    import ascon_pack::*;

    logic          clock_i;
    logic          resetb_i;
    logic          en_i;
    logic [1:0]    etat_i;
    logic [127:0]  xor_key_i;
    logic [63:0]   xor_data_i;
    type_state     xor_i;
    type_state     xor_o;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [127:0] K_C = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [63:0]  D_C = 64'h3230323380000000;
    localparam logic [319:0] S_C = {64'h1b1354db77e0dbb4, 64'h6f140401cfa0873c,
                                    64'hd7e8abaf45f2885a, 64'hc0c5777fa661625e,
                                    64'hfc4374d28210928c};

    xor_up dut (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .en_i       (en_i),
        .etat_i     (etat_i),
        .xor_key_i  (xor_key_i),
        .xor_data_i (xor_data_i),
        .xor_i      (xor_i),
        .xor_o      (xor_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Reference: the update is the state XORed with a 320-bit mask built from the
    // mode bits (bit0 enables the data word, bit1 enables the key on words 1..2).
    function automatic logic [319:0] ref_next(input logic [319:0] s, input logic [1:0] mode,
                                              input logic [63:0] d, input logic [127:0] k);
        logic [319:0] mask;
        mask = {(mode[0] ? d : 64'h0), (mode[1] ? k : 128'h0), 128'h0};
        return s ^ mask;
    endfunction

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        logic [319:0] exp;
        logic [319:0] s_rnd;
        logic [1:0]   m_rnd;
        logic [63:0]  d_rnd;
        logic [127:0] k_rnd;
        logic         e_rnd;

        // 1) reset with arbitrary inputs, checked before any clock edge
        resetb_i   = 1'b0;
        en_i       = 1'b1;
        etat_i     = 2'b11;
        xor_key_i  = {$urandom, $urandom, $urandom, $urandom};
        xor_data_i = {$urandom, $urandom};
        xor_i      = {$urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom};
        #2;
        check("reset_no_clock", xor_o, 320'h0);
        tick();
        check("reset_held_edge", xor_o, 320'h0);
        #2;
        resetb_i   = 1'b1;
        xor_key_i  = K_C;
        xor_data_i = D_C;
        xor_i      = S_C;

        // 2) data absorb
        etat_i = XOR_DATA;
        tick();
        check_w("data_w0", xor_o[0], 64'h292366e8f7e0dbb4);
        check("data_rest", {64'h0, xor_o[1], xor_o[2], xor_o[3], xor_o[4]},
              {64'h0, S_C[255:0]});

        // 3) key injection
        etat_i = XOR_KEY;
        tick();
        check_w("key_w1", xor_o[1], 64'h6f150602cba5813b);
        check_w("key_w2", xor_o[2], 64'hdfe1a1a449ff8655);
        check_w("key_w0", xor_o[0], S_C[319:256]);
        check("key_w34", {xor_o[3], xor_o[4]}, S_C[127:0]);

        // 4) both
        etat_i = XOR_BOTH;
        tick();
        check("both_all", xor_o, {64'h292366e8f7e0dbb4, 64'h6f150602cba5813b,
                                  64'hdfe1a1a449ff8655, S_C[127:0]});

        // 5) pass, then hold with en low while inputs move
        etat_i = XOR_PASS;
        tick();
        check("pass_all", xor_o, S_C);
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            etat_i     = 2'(i);
            xor_i      = {$urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom, $urandom};
            xor_data_i = {$urandom, $urandom};
            tick();
            check($sformatf("hold_%0d", i), xor_o, S_C);
        end

        // 6) async reset between edges after a load, then reload
        en_i   = 1'b1;
        etat_i = XOR_BOTH;
        xor_i  = S_C;
        xor_data_i = D_C;
        tick();
        check("preload_both", xor_o, ref_next(S_C, XOR_BOTH, D_C, K_C));
        #2;
        resetb_i = 1'b0;
        #1;
        check("async_clear", xor_o, 320'h0);
        #3;
        resetb_i = 1'b1;
        etat_i   = XOR_DATA;
        tick();
        check("reload_data", xor_o, {64'h292366e8f7e0dbb4, S_C[255:0]});

        // randomized traffic against the mask reference
        exp = xor_o;
        for (int i = 0; i < 300; i++) begin
            s_rnd = {$urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom};
            m_rnd = 2'($urandom_range(0, 3));
            d_rnd = {$urandom, $urandom};
            k_rnd = {$urandom, $urandom, $urandom, $urandom};
            e_rnd = ($urandom_range(0, 3) != 0);
            en_i       = e_rnd;
            etat_i     = m_rnd;
            xor_i      = s_rnd;
            xor_data_i = d_rnd;
            xor_key_i  = k_rnd;
            tick();
            if (e_rnd) exp = ref_next(s_rnd, m_rnd, d_rnd, k_rnd);
            check($sformatf("rand_%0d", i), xor_o, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
